// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch front end between the PC register, an SRAM-like
// instruction memory and the decode stage.
//
// Keeps at most one memory request outstanding. Fetched instructions go into a 2-entry
// FIFO whose head is presented to decode. Misaligned PCs produce an address-error entry
// and no memory request. A redirect reloads the PC, flushes the FIFO and cancels any
// outstanding request, so the data it later returns is discarded.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   pc                  current fetch PC
//   go_if, pc_in        PC register advance strobe and next PC
//   redirect_valid/_pc  branch/exception redirect pulse and target
//   inst_req/_addr      memory request and address
//   inst_addr_ok        request accepted this cycle
//   inst_data_ok/rdata  read data returned this cycle
//   ds_valid/ds_ready   decode handshake for the FIFO head
//   ds_inst/ds_pc/adel  head entry contents
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic        go_if,
    output logic [31:0] pc_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        ds_valid,
    input  logic        ds_ready,
    output logic [31:0] ds_inst,
    output logic [31:0] ds_pc,
    output logic        ds_adel
);

    // StWaitCancel: request outstanding but its data must be dropped.
    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StWait       = 2'd1,
        StWaitCancel = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [31:0] r_inst [2];
    logic [31:0] r_pc   [2];
    logic [1:0]  r_adel;
    logic        r_head;
    logic [1:0]  r_count;
    logic [31:0] r_resp_pc;

    logic        w_outstanding;
    logic        w_aligned;
    logic        w_has_space;
    logic        w_accept;
    logic        w_misalign_push;
    logic        w_data_push;
    logic        w_push;
    logic        w_pop;
    logic        w_wr_idx;
    logic [31:0] w_push_inst;
    logic [31:0] w_push_pc;
    logic        w_push_adel;

    always_comb begin
        w_outstanding   = (r_state != StIdle);
        w_aligned       = (pc[1:0] == 2'b00);
        w_has_space     = ((r_count + {1'b0, w_outstanding}) < 2'd2);

        inst_req        = rst_n && w_aligned && !w_outstanding && w_has_space;
        inst_addr       = pc;
        w_accept        = inst_req && inst_addr_ok;

        w_misalign_push = rst_n && !w_aligned && !w_outstanding && w_has_space;
        // Only an uncancelled request's data is kept; a same-cycle redirect also drops it.
        w_data_push     = (r_state == StWait) && inst_data_ok && !redirect_valid;
        w_push          = w_data_push || w_misalign_push;

        go_if           = rst_n && (redirect_valid || w_accept || w_misalign_push);
        pc_in           = redirect_valid ? redirect_pc : (pc + 32'd4);

        ds_valid        = rst_n && (r_count != 2'd0);
        w_pop           = ds_valid && ds_ready;

        // Tail slot; a push never happens with the FIFO full.
        w_wr_idx        = r_head ^ r_count[0];
        w_push_inst     = w_data_push ? inst_rdata : 32'h0;
        w_push_pc       = w_data_push ? r_resp_pc  : pc;
        w_push_adel     = !w_data_push;

        ds_inst         = r_inst[r_head];
        ds_pc           = r_pc[r_head];
        ds_adel         = r_adel[r_head];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = redirect_valid ? StWaitCancel : StWait;
                end
            end
            StWait: begin
                if (inst_data_ok) begin
                    w_state_next = StIdle;
                end else if (redirect_valid) begin
                    w_state_next = StWaitCancel;
                end
            end
            StWaitCancel: begin
                if (inst_data_ok) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_count   <= 2'd0;
            r_head    <= 1'b0;
            r_resp_pc <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_resp_pc <= pc;
            end
            if (redirect_valid) begin
                r_count <= 2'd0;
                r_head  <= 1'b0;
            end else begin
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
                if (w_pop) begin
                    r_head <= ~r_head;
                end
            end
        end
    end

    // Payload storage needs no reset; validity comes from r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[w_wr_idx] <= w_push_inst;
            r_pc[w_wr_idx]   <= w_push_pc;
            r_adel[w_wr_idx] <= w_push_adel;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: scoreboard bench for if_fetch_ctrl.
// The driver owns the PC register and the memory, predicts per-cycle outputs and the
// decode entry stream, and queues them; the monitor compares at the falling edge.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = RESET_PC;
    logic        go_if;
    logic [31:0] pc_in;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'h0;
    logic        ds_valid;
    logic        ds_ready = 1'b0;
    logic [31:0] ds_inst;
    logic [31:0] ds_pc;
    logic        ds_adel;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .go_if          (go_if),
        .pc_in          (pc_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .ds_valid       (ds_valid),
        .ds_ready       (ds_ready),
        .ds_inst        (ds_inst),
        .ds_pc          (ds_pc),
        .ds_adel        (ds_adel)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } entry_t;

    typedef struct packed {
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic        go;
        logic [31:0] pcin;
    } cyc_t;

    entry_t exp_q[$];   // entries decode should see, oldest first
    cyc_t   cyc_q[$];   // per-cycle expected control outputs

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the memory transaction in flight and the PC register.
    bit          m_pending = 1'b0;
    bit          m_cancel  = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;
    bit          stray     = 1'b0;
    logic [31:0] pc_next   = RESET_PC;

    // Outputs sampled in the last step, for directed checks.
    logic        s_req, s_go, s_dsv, s_adel;
    logic [31:0] s_addr, s_pcin, s_inst, s_dspc;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares control outputs every cycle and the FIFO head on each pop.
    always @(negedge clk) begin
        cyc_t   c;
        entry_t e;
        if (cyc_q.size() != 0) begin
            c = cyc_q.pop_front();
            chk("inst_req", {31'h0, inst_req}, {31'h0, c.req});
            if (c.req) chk("inst_addr", inst_addr, c.addr);
            chk("go_if", {31'h0, go_if}, {31'h0, c.go});
            if (c.go) chk("pc_in", pc_in, c.pcin);
            if (!c.rst) begin
                chk("ds_valid_in_reset", {31'h0, ds_valid}, 32'h0);
            end else begin
                chk("ds_valid", {31'h0, ds_valid}, {31'h0, exp_q.size() != 0});
                if (exp_q.size() != 0 && ds_ready) begin
                    e = exp_q.pop_front();
                    chk("ds_inst", ds_inst, e.inst);
                    chk("ds_pc", ds_pc, e.pc);
                    chk("ds_adel", {31'h0, ds_adel}, {31'h0, e.adel});
                end
            end
        end
    end

    // One clock cycle: drive inputs, predict outputs, then advance the model.
    task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                        input logic aok, input logic dok, input logic [31:0] rdat,
                        input logic rdy);
        cyc_t c;
        logic room, e_req, e_mis, e_acc;
        @(posedge clk);
        #1;
        pc             = pc_next;
        rst_n          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_addr_ok   = aok;
        inst_data_ok   = dok;
        inst_rdata     = rdat;
        ds_ready       = rdy;

        // Fetch proceeds only with nothing in flight and a free FIFO slot.
        room   = !m_pending && (exp_q.size() < 2);
        e_req  = rst && (pc[1:0] == 2'b00) && room;
        e_mis  = rst && (pc[1:0] != 2'b00) && room;
        e_acc  = e_req && aok;
        c.rst  = rst;
        c.req  = e_req;
        c.addr = pc;
        c.go   = rst && (redir || e_acc || e_mis);
        c.pcin = redir ? rpc : pc + 32'd4;
        cyc_q.push_back(c);

        @(negedge clk);
        #1;
        s_req  = inst_req;
        s_addr = inst_addr;
        s_go   = go_if;
        s_pcin = pc_in;
        s_dsv  = ds_valid;
        s_inst = ds_inst;
        s_dspc = ds_pc;
        s_adel = ds_adel;
        pc_next = !rst ? RESET_PC : (go_if ? pc_in : pc);

        if (!rst) begin
            exp_q.delete();
            if (m_pending) stray = 1'b1;
            m_pending = 1'b0;
            m_cancel  = 1'b0;
        end else begin
            if (m_pending && dok) begin
                if (!m_cancel && !redir) exp_q.push_back('{inst: rdat, pc: m_pend_pc, adel: 1'b0});
                m_pending = 1'b0;
                m_cancel  = 1'b0;
            end else if (dok) begin
                stray = 1'b0;
            end
            if (e_mis) exp_q.push_back('{inst: 32'h0, pc: pc, adel: 1'b1});
            if (e_acc) begin
                m_pending = 1'b1;
                m_pend_pc = pc;
                m_cancel  = redir;
                stray     = 1'b0;
            end
            if (redir) begin
                exp_q.delete();
                if (m_pending) m_cancel = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic        r, rd, ak, dk, ry;
        logic [31:0] rp, tmp;

        // First fetch: accept, then data, then decode sees it.
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("first_req", {31'h0, s_req}, 32'h1);
        chk("first_pc_in", s_pcin, 32'hBFC00004);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h24080001, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("first_ds_valid", {31'h0, s_dsv}, 32'h1);
        chk("first_ds_inst", s_inst, 32'h24080001);
        chk("first_ds_pc", s_dspc, 32'hBFC00000);

        // Decode stalled: FIFO fills with two entries and fetch stops.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h11110000 + i, 1'b0);
        end
        chk("full_no_req", {31'h0, s_req}, 32'h0);
        chk("full_head_pc", s_dspc, 32'hBFC00000);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("after_pop_req", {31'h0, s_req}, 32'h1);
        chk("after_pop_addr", s_addr, 32'hBFC00008);
        chk("after_pop_head", s_dspc, 32'hBFC00004);

        // Redirect while outstanding: returned data is dropped.
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h80001000, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_go", {31'h0, s_go}, 32'h1);
        chk("redir_pc_in", s_pcin, 32'h80001000);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("cancel_no_req", {31'h0, s_req}, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("cancel_empty", {31'h0, s_dsv}, 32'h0);
        chk("cancel_next_addr", s_addr, 32'h80001000);

        // Misaligned PC: address-error entry, no memory request.
        do_reset();
        pc_next = 32'h80000002;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("adel_no_req", {31'h0, s_req}, 32'h0);
        chk("adel_pc_in", s_pcin, 32'h80000006);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("adel_flag", {31'h0, s_adel}, 32'h1);
        chk("adel_inst", s_inst, 32'h0);
        chk("adel_pc", s_dspc, 32'h80000002);

        // Reset mid-transaction, stray data afterwards.
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b1);
        chk("post_rst_req", {31'h0, s_req}, 32'h1);
        chk("post_rst_addr", s_addr, RESET_PC);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("stray_ignored", {31'h0, s_dsv}, 32'h0);

        // PC wrap.
        do_reset();
        pc_next = 32'hFFFFFFFC;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("wrap_go", {31'h0, s_go}, 32'h1);
        chk("wrap_pc_in", s_pcin, 32'h0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tmp = $urandom;
            r   = ($urandom_range(0, 149) != 0);
            rd  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 7))
                0:       rp = 32'hFFFFFFFC;
                1:       rp = {tmp[31:2], 2'b10};
                default: rp = {tmp[31:2], 2'b00};
            endcase
            ak = ($urandom_range(0, 1) == 1);
            ry = ($urandom_range(0, 3) != 0);
            dk = m_pending ? ($urandom_range(0, 2) == 0) : (stray && $urandom_range(0, 1) == 1);
            step(r, rd, rp, ak, dk, $urandom, ry);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC00000, PC reported on ds_pc for the first fetch after reset (informational; fetch address always taken from pc).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 pc  input  32  current fetch PC from the PC register.
REQ-005 go_if  output  1  advance the PC register this cycle.
REQ-006 pc_in  output  32  next PC loaded by the PC register when go_if=1.
REQ-007 redirect_valid  input  1  branch/exception redirect, single-cycle pulse.
REQ-008 redirect_pc  input  32  redirect target.
REQ-009 inst_req  output  1  instruction memory request (SRAM-like).
REQ-010 inst_addr  output  32  request address.
REQ-011 inst_addr_ok  input  1  request accepted this cycle.
REQ-012 inst_data_ok  input  1  read data returned this cycle.
REQ-013 inst_rdata  input  32  returned instruction.
REQ-014 ds_valid  output  1  decode-side entry valid.
REQ-015 ds_ready  input  1  decode accepts entry this cycle.
REQ-016 ds_inst  output  32  instruction of head entry.
REQ-017 ds_pc  output  32  PC of head entry.
REQ-018 ds_adel  output  1  head entry has address-error (misaligned PC).

Function
REQ-019 Internal 2-entry FIFO {inst, pc, adel}; ds_* present the head; pop on ds_valid&&ds_ready.
REQ-020 At most one outstanding request (accepted, data not yet returned); outstanding flag set on inst_req&&inst_addr_ok, cleared on inst_data_ok.
REQ-021 inst_req=1 iff pc[1:0]==0, no outstanding request, and (fifo_count + outstanding) < 2; inst_addr=pc.
REQ-022 Unaccepted request may change address or drop (no commitment before inst_addr_ok).
REQ-023 go_if=1 with pc_in=pc+4 in the cycle inst_req&&inst_addr_ok, absent redirect.
REQ-024 Misaligned pc (pc[1:0]!=0) with FIFO space and no outstanding request: no memory request; push {inst=0, pc, adel=1}; go_if=1, pc_in=pc+4.
REQ-025 Data return: on inst_data_ok with cancel=0, push {inst_rdata, PC of the request, adel=0}; response PC held in a register captured at acceptance.
REQ-026 Redirect: go_if=1, pc_in=redirect_pc same cycle (overrides REQ-023/024); FIFO flushed next edge; any outstanding request, including one accepted this same cycle, marked cancel.
REQ-027 cancel=1: next inst_data_ok discarded, cancel cleared; no new request issued while outstanding.
REQ-028 Redirect with inst_data_ok same cycle: returned data discarded, cancel not set for it.
REQ-029 Push and pop same cycle: count unchanged; push never overflows (guaranteed by REQ-021).
REQ-030 pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-031 FSM states IDLE (no outstanding), WAIT (outstanding, valid), WAIT_CANCEL (outstanding, cancelled); IDLE->WAIT on accept, WAIT->IDLE on data_ok, WAIT->WAIT_CANCEL on redirect, WAIT_CANCEL->IDLE on data_ok; IDLE->WAIT_CANCEL on accept coincident with redirect.

Reset
REQ-032 While rst_n=0: inst_req=0, go_if=0, ds_valid=0, FIFO empty, state IDLE, cancel=0; inst_data_ok ignored.
REQ-033 Reset mid-transaction abandons the outstanding request; a stray inst_data_ok in IDLE after reset is ignored.
REQ-034 First inst_req asserted in the first cycle with rst_n=1.

Verification
REQ-035 pc=BFC00000, addr_ok same cycle, data_ok next cycle rdata=24080001, ds_ready=1 -> go_if pulse with pc_in=BFC00004; ds_valid with ds_inst=24080001, ds_pc=BFC00000.
REQ-036 ds_ready=0, memory always ready -> exactly two entries fetched (PCs BFC00000, BFC00004); inst_req stays 0 until a pop.
REQ-037 Redirect to 80001000 in the cycle after accept, data_ok two cycles later -> data discarded, FIFO empty, next request addr 80001000.
REQ-038 pc=80000002 -> no inst_req, entry with ds_adel=1, ds_inst=0, ds_pc=80000002, pc_in=80000006.
REQ-039 rst_n=0 while outstanding, then data_ok after release -> ds_valid stays 0, inst_req at first reset-free cycle.
REQ-040 pc=FFFFFFFC accepted -> pc_in=00000000.
